fifo_stream_reader: RTL and testbench

Read-side adapter for the team's `synchronous_fifo`. It drains the FIFO through its `r_en`/`data_out`/`empty` port and presents the words as a valid/ready stream to a downstream consumer. The block hides the FIFO's one-cycle read latency behind a small circular skid buffer, sustains one word per clock, and never reads the FIFO when empty. It sits between `synchronous_fifo` and any stream sink: DMA engine, serializer or checker.

---
 rtl/fifo_stream_reader_if.sv | 22 ++
 rtl/fifo_stream_reader.sv | 60 ++++++
 tb/tb_fifo_stream_reader.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/fifo_stream_reader_if.sv
// Handshake bundle between synchronous_fifo's read port, the reader and a stream sink.
// master = the reader; slave = whatever drives the FIFO side and consumes the stream.
interface fifo_stream_reader_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  fifo_empty;
    logic [DATA_WIDTH-1:0] fifo_data;
    logic                  fifo_r_en;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;

    modport master (
        input  fifo_empty, fifo_data, m_ready,
        output fifo_r_en, m_valid, m_data
    );

    modport slave (
        output fifo_empty, fifo_data, m_ready,
        input  fifo_r_en, m_valid, m_data
    );
endinterface

// File: rtl/fifo_stream_reader.sv
// Drains a synchronous_fifo (one-cycle read latency) into a valid/ready stream through a
// circular skid buffer, so reads can run ahead of the consumer without ever overflowing.
module fifo_stream_reader #(
    parameter int DATA_WIDTH = 8,
    parameter int BUF_DEPTH  = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    fifo_stream_reader_if.master        bus,
    output logic [$clog2(BUF_DEPTH):0]  buf_count
);
    localparam int PTR_W = $clog2(BUF_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef logic [PTR_W-1:0] ptr_t;
    typedef logic [CNT_W-1:0] cnt_t;

    logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
    ptr_t                  wr_ptr;
    ptr_t                  rd_ptr;
    cnt_t                  count;
    logic                  inflight;
    cnt_t                  occ;
    logic                  capture;
    logic                  pop;

    // A word already requested from the FIFO still needs a slot, so it counts toward occupancy.
    assign occ           = count + cnt_t'(inflight);
    assign capture       = inflight && !flush;
    assign pop           = bus.m_valid && bus.m_ready && !flush;
    assign bus.fifo_r_en = !bus.fifo_empty && !flush && (occ < cnt_t'(BUF_DEPTH));
    assign bus.m_valid   = (count != '0);
    assign bus.m_data    = mem[rd_ptr];
    assign buf_count     = count;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            inflight <= 1'b0;
        end else if (flush) begin
            count    <= '0;
            rd_ptr   <= wr_ptr;
            inflight <= 1'b0;
        end else begin
            inflight <= bus.fifo_r_en;
            if (capture) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            count <= count + cnt_t'(capture) - cnt_t'(pop);
        end
    end

    // NOTE: storage is not reset; m_valid derives from count, so stale entries are never visible.
    always_ff @(posedge clk) begin
        if (capture) mem[wr_ptr] <= bus.fifo_data;
    end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomised bench for fifo_stream_reader: a queue-based FIFO model feeds the DUT and a
// queue scoreboard predicts occupancy, handshake outputs and the delivered word order.
module tb_fifo_stream_reader;
    localparam int DW = 8;
    localparam int BD = 4;
    localparam int CW = $clog2(BD) + 1;

    logic          clk   = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic [CW-1:0] buf_count;

    fifo_stream_reader_if #(.DATA_WIDTH(DW)) bus ();

    fifo_stream_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(BD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .bus       (bus),
        .buf_count (buf_count)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // FIFO contents, words read but not yet accepted (oldest first), accepted words, reference words
    logic [DW-1:0] fifo_q [$];
    logic [DW-1:0] exp_q  [$];
    logic [DW-1:0] got_q  [$];
    logic [DW-1:0] sent_q [$];
    bit            inflight_m = 0;
    int            cyc = 0;
    int            reads = 0;
    int            accepted = 0;
    int            prev_acc = -1;
    int            gaps = 0;
    int            first_valid = -1;
    bit            s_valid;

    task automatic push(input logic [DW-1:0] d);
        fifo_q.push_back(d);
        sent_q.push_back(d);
        bus.fifo_empty = 1'b0;
    endtask

    task automatic clear_phase();
        got_q.delete();
        sent_q.delete();
        accepted    = 0;
        prev_acc    = -1;
        gaps        = 0;
        first_valid = -1;
        reads       = 0;
    endtask

    // One clock cycle: called at the falling edge with inputs already applied.
    task automatic step();
        bit            rd;
        bit            acc;
        int            exp_cnt;
        int            s_cyc;
        logic [DW-1:0] s_data;
        logic [DW-1:0] d;
        #1;
        s_cyc   = cyc;
        exp_cnt = exp_q.size() - int'(inflight_m);
        check("r_en_while_empty", 32'(bus.fifo_r_en & bus.fifo_empty), 32'd0);
        check("fifo_r_en", 32'(bus.fifo_r_en),
              32'(!bus.fifo_empty && !flush && rst_n && (exp_q.size() < BD)));
        check("buf_count", 32'(buf_count), 32'(exp_cnt));
        check("m_valid", 32'(bus.m_valid), 32'(exp_cnt != 0));
        if (exp_cnt != 0) check("m_data", 32'(bus.m_data), 32'(exp_q[0]));
        s_valid = bus.m_valid;
        s_data  = bus.m_data;
        if (s_valid && first_valid < 0) first_valid = s_cyc;
        rd  = bus.fifo_r_en && !bus.fifo_empty;
        acc = bus.m_valid && bus.m_ready && !flush && rst_n;
        @(posedge clk);
        #1;
        cyc++;
        if (flush || !rst_n) begin
            exp_q.delete();
        end else if (acc) begin
            got_q.push_back(s_data);
            accepted++;
            if (prev_acc >= 0 && s_cyc != prev_acc + 1) gaps++;
            prev_acc = s_cyc;
            if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
        inflight_m = 0;
        if (rd && fifo_q.size() > 0) begin
            d = fifo_q.pop_front();
            bus.fifo_data = d;
            reads++;
            if (!flush && rst_n) begin
                exp_q.push_back(d);
                inflight_m = 1;
            end
            if (fifo_q.size() == 0) bus.fifo_empty = 1'b1;
        end
        @(negedge clk);
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_count"}, 32'(got_q.size()), 32'(sent_q.size()));
        for (int i = 0; i < got_q.size() && i < sent_q.size(); i++)
            check(tag, 32'(got_q[i]), 32'(sent_q[i]));
    endtask

    initial begin
        int            c0;
        int            pushed;
        logic [DW-1:0] w0;

        bus.fifo_empty = 1'b1;
        bus.fifo_data  = '0;
        bus.m_ready    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Idle after reset with an empty FIFO
        for (int i = 0; i < 20; i++) step();
        check("idle_m_valid", 32'(bus.m_valid), 32'd0);
        check("idle_buf_count", 32'(buf_count), 32'd0);

        // Latency and back-to-back delivery
        clear_phase();
        bus.m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33);
        c0 = cyc;
        for (int i = 0; i < 20 && accepted < 3; i++) step();
        check("latency", 32'(first_valid - c0), 32'd2);
        check("burst_gaps", 32'(gaps), 32'd0);
        compare_stream("burst_word");
        repeat (3) step();

        // Backpressure fills the buffer, then drains gap-free
        clear_phase();
        bus.m_ready = 1'b0;
        for (int i = 0; i < 16; i++) push(DW'($urandom));
        w0 = sent_q[0];
        repeat (10) step();
        #1;
        check("bp_reads", 32'(reads), 32'd4);
        check("bp_buf_count", 32'(buf_count), 32'd4);
        check("bp_r_en", 32'(bus.fifo_r_en), 32'd0);
        check("bp_m_data", 32'(bus.m_data), 32'(w0));
        bus.m_ready = 1'b1;
        for (int i = 0; i < 60 && accepted < 16; i++) step();
        check("bp_gaps", 32'(gaps), 32'd0);
        compare_stream("bp_word");
        repeat (3) step();

        // Alternating ready
        clear_phase();
        for (int i = 0; i < 30; i++) push(DW'($urandom));
        for (int i = 0; i < 300 && accepted < 30; i++) begin
            bus.m_ready = logic'(i % 2);
            step();
        end
        compare_stream("alt_word");

        // Random pushes and random ready
        clear_phase();
        pushed = 0;
        for (int i = 0; i < 3000 && accepted < 200; i++) begin
            if (pushed < 200 && $urandom_range(0, 2) != 0) begin
                push(DW'($urandom));
                pushed++;
            end
            bus.m_ready = logic'($urandom_range(0, 1));
            step();
        end
        compare_stream("rand_word");
        bus.m_ready = 1'b0;
        repeat (3) step();

        // Flush with two buffered words and one word in flight
        clear_phase();
        push(8'h01); push(8'h02);
        repeat (5) step();
        check("pre_flush_count", 32'(buf_count), 32'd2);
        push(8'h5A);
        step();
        check("flush_read_issued", 32'(reads), 32'd3);
        flush = 1'b1;
        step();
        flush = 1'b0;
        #1;
        check("flush_buf_count", 32'(buf_count), 32'd0);
        check("flush_m_valid", 32'(bus.m_valid), 32'd0);
        clear_phase();
        push(8'hC3);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        compare_stream("post_flush_word");

        // Asynchronous reset mid-stream
        clear_phase();
        bus.m_ready = 1'b0;
        push(8'hA1); push(8'hA2); push(8'hA3);
        repeat (5) step();
        check("pre_reset_count", 32'(buf_count), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_rst_m_valid", 32'(bus.m_valid), 32'd0);
        check("async_rst_buf_count", 32'(buf_count), 32'd0);
        fifo_q.delete();
        exp_q.delete();
        inflight_m     = 0;
        bus.fifo_empty = 1'b1;
        repeat (2) step();
        rst_n = 1'b1;
        step();
        clear_phase();
        push(8'h77); push(8'h88);
        bus.m_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        compare_stream("post_reset_word");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
